cbfp1_shift_apply: RTL and testbench

//  Consumer side of the CBFP stage-1 block-exponent path. Delays the stage-1 butterfly
//  add/sub data (8 R + 8 Q samples per path per cycle) to line up with the pipelined
//  min-LZC results. Shifts each sample left by its path's min LZC, then rounds and

---
 rtl/cbfp_pkg.sv | 35 +++
 rtl/cbfp1_norm_lane.sv | 17 +
 rtl/cbfp1_shift_apply.sv | 111 +++++++++++
 tb/tb_cbfp1_shift_apply.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cbfp_pkg.sv
// Shared CBFP widths, sample types and the round/saturate step used by every CBFP stage.
// Combinational helpers only, no state; no flow control of its own.
package cbfp_pkg;

    localparam int IN_WIDTH     = 23;
    localparam int OUT_WIDTH    = 11;
    localparam int LZC_WIDTH    = 5;
    localparam int SMP_PER_PATH = 8;
    localparam int NUM_SMP      = 4 * SMP_PER_PATH;
    localparam int MAX_OUT      = 2 ** (OUT_WIDTH - 1) - 1;

    typedef logic signed [IN_WIDTH-1:0]  in_smp_t;
    typedef logic signed [OUT_WIDTH-1:0] out_smp_t;
    typedef logic        [LZC_WIDTH-1:0] lzc_t;

    localparam lzc_t MAX_SH = lzc_t'(IN_WIDTH - 1);

    // Keep the top OUT_WIDTH bits, rounding half-up on the first discarded bit.
    function automatic out_smp_t round_sat(input in_smp_t t);
        logic signed [IN_WIDTH:0]  s;
        logic signed [OUT_WIDTH:0] r;
        s = $signed({t[IN_WIDTH-1], t}) + $signed((IN_WIDTH + 1)'(1 << (IN_WIDTH - OUT_WIDTH - 1)));
        r = (OUT_WIDTH + 1)'(s >>> (IN_WIDTH - OUT_WIDTH));
        if (r > MAX_OUT) begin
            return out_smp_t'(MAX_OUT);
        end
        return out_smp_t'(r);
    endfunction

    // An all-zero block reports the maximum LZC; never shift past the sign bit.
    function automatic lzc_t clamp_sh(input lzc_t m);
        return (m > MAX_SH) ? MAX_SH : m;
    endfunction

endpackage

// File: rtl/cbfp1_norm_lane.sv
// One-sample normaliser: left shift by the block exponent, then round and saturate.
// Latency: combinational.
// Backpressure: none.
module cbfp1_norm_lane
    import cbfp_pkg::*;
(
    input  in_smp_t  din,
    input  lzc_t     sh,
    output out_smp_t dout
);

    in_smp_t t;

    assign t    = din <<< sh;
    assign dout = round_sat(t);

endmodule

// File: rtl/cbfp1_shift_apply.sv
// Stage-1 CBFP normaliser: aligns butterfly data with its min-LZC, shifts, rounds, saturates.
// Latency: valid_out follows valid_in by MIN_LAT+1 en-cycles.
// Backpressure: none; en=0 freezes every register, bubbles pass through as valid_out=0.
module cbfp1_shift_apply
    import cbfp_pkg::*;
#(
    parameter int MIN_LAT        = 2,
    parameter int BLKS_PER_FRAME = 32,
    parameter int IDX_WIDTH      = $clog2(BLKS_PER_FRAME)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 en,
    input  logic                 valid_in,
    input  in_smp_t              din_R_add [SMP_PER_PATH],
    input  in_smp_t              din_Q_add [SMP_PER_PATH],
    input  in_smp_t              din_R_sub [SMP_PER_PATH],
    input  in_smp_t              din_Q_sub [SMP_PER_PATH],
    input  lzc_t                 min_in_add,
    input  lzc_t                 min_in_sub,
    output logic                 valid_out,
    output out_smp_t             dout_R_add [SMP_PER_PATH],
    output out_smp_t             dout_Q_add [SMP_PER_PATH],
    output out_smp_t             dout_R_sub [SMP_PER_PATH],
    output out_smp_t             dout_Q_sub [SMP_PER_PATH],
    output lzc_t                 exp_add,
    output lzc_t                 exp_sub,
    output logic [IDX_WIDTH-1:0] blk_idx,
    output logic                 blk_last
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(BLKS_PER_FRAME - 1);

    // Flat sample order: R_add, Q_add, R_sub, Q_sub; the first half uses the add exponent.
    in_smp_t              din_all [NUM_SMP];
    in_smp_t              dly     [MIN_LAT][NUM_SMP];
    logic [MIN_LAT-1:0]   vld_dly;
    out_smp_t             norm    [NUM_SMP];
    out_smp_t             dout_q  [NUM_SMP];
    lzc_t                 sh_add;
    lzc_t                 sh_sub;
    logic [IDX_WIDTH-1:0] nxt_idx;
    logic                 aligned_vld;

    for (genvar g = 0; g < SMP_PER_PATH; g++) begin : g_io
        assign din_all[g]                    = din_R_add[g];
        assign din_all[g + SMP_PER_PATH]     = din_Q_add[g];
        assign din_all[g + 2 * SMP_PER_PATH] = din_R_sub[g];
        assign din_all[g + 3 * SMP_PER_PATH] = din_Q_sub[g];
        assign dout_R_add[g] = dout_q[g];
        assign dout_Q_add[g] = dout_q[g + SMP_PER_PATH];
        assign dout_R_sub[g] = dout_q[g + 2 * SMP_PER_PATH];
        assign dout_Q_sub[g] = dout_q[g + 3 * SMP_PER_PATH];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_dly <= '0;
            for (int s = 0; s < MIN_LAT; s++) begin
                for (int i = 0; i < NUM_SMP; i++) begin
                    dly[s][i] <= '0;
                end
            end
        end else if (en) begin
            vld_dly[0] <= valid_in;
            dly[0]     <= din_all;
            for (int s = 1; s < MIN_LAT; s++) begin
                vld_dly[s] <= vld_dly[s-1];
                dly[s]     <= dly[s-1];
            end
        end
    end

    assign aligned_vld = vld_dly[MIN_LAT-1];
    assign sh_add      = clamp_sh(min_in_add);
    assign sh_sub      = clamp_sh(min_in_sub);

    for (genvar g = 0; g < NUM_SMP; g++) begin : g_lane
        cbfp1_norm_lane u_lane (
            .din  (dly[MIN_LAT-1][g]),
            .sh   ((g < 2 * SMP_PER_PATH) ? sh_add : sh_sub),
            .dout (norm[g])
        );
    end

    // nxt_idx is the index the next valid block will carry; blk_idx shows the current one.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_out <= 1'b0;
            exp_add   <= '0;
            exp_sub   <= '0;
            blk_idx   <= '0;
            nxt_idx   <= '0;
            for (int i = 0; i < NUM_SMP; i++) begin
                dout_q[i] <= '0;
            end
        end else if (en) begin
            valid_out <= aligned_vld;
            if (aligned_vld) begin
                dout_q  <= norm;
                exp_add <= sh_add;
                exp_sub <= sh_sub;
                blk_idx <= nxt_idx;
                nxt_idx <= (nxt_idx == LAST_IDX) ? '0 : nxt_idx + IDX_WIDTH'(1);
            end
        end
    end

    assign blk_last = valid_out && (blk_idx == LAST_IDX);

endmodule

// File: tb/tb_cbfp1_shift_apply.sv
// Randomised scoreboard bench for cbfp1_shift_apply with an arithmetic reference model.
module tb_cbfp1_shift_apply;
    import cbfp_pkg::*;

    localparam int MIN_LAT = 2;
    localparam int BLKS    = 32;

    typedef struct packed {
        logic [31:0][10:0] d;
        logic [4:0]        ea;
        logic [4:0]        eb;
        logic [4:0]        idx;
        logic [31:0]       edge_n;
    } exp_t;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       en = 1'b0;
    logic       valid_in = 1'b0;
    in_smp_t    din_R_add [8];
    in_smp_t    din_Q_add [8];
    in_smp_t    din_R_sub [8];
    in_smp_t    din_Q_sub [8];
    lzc_t       min_in_add = '0;
    lzc_t       min_in_sub = '0;
    logic       valid_out;
    out_smp_t   dout_R_add [8];
    out_smp_t   dout_Q_add [8];
    out_smp_t   dout_R_sub [8];
    out_smp_t   dout_Q_sub [8];
    lzc_t       exp_add;
    lzc_t       exp_sub;
    logic [4:0] blk_idx;
    logic       blk_last;

    exp_t       sbq[$];
    lzc_t       mq_a[$];
    lzc_t       mq_b[$];
    int         n_checks = 0;
    int         n_fail = 0;
    int         model_idx = 0;
    int         ecnt = 0;
    logic       upd = 1'b0;

    cbfp1_shift_apply #(.MIN_LAT(MIN_LAT), .BLKS_PER_FRAME(BLKS)) dut (
        .clk(clk), .rstn(rstn), .en(en), .valid_in(valid_in),
        .din_R_add(din_R_add), .din_Q_add(din_Q_add),
        .din_R_sub(din_R_sub), .din_Q_sub(din_Q_sub),
        .min_in_add(min_in_add), .min_in_sub(min_in_sub),
        .valid_out(valid_out),
        .dout_R_add(dout_R_add), .dout_Q_add(dout_Q_add),
        .dout_R_sub(dout_R_sub), .dout_Q_sub(dout_Q_sub),
        .exp_add(exp_add), .exp_sub(exp_sub),
        .blk_idx(blk_idx), .blk_last(blk_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic int ref_sh(input int m);
        return (m > IN_WIDTH - 1) ? IN_WIDTH - 1 : m;
    endfunction

    // Scale by 2^sh, wrap to 23-bit two's complement, divide by 2^12 rounding half-up, clip.
    function automatic int ref_norm(input int din, input int m);
        longint v;
        v = longint'(din) * (longint'(1) << ref_sh(m));
        v = v & ((longint'(1) << 23) - 1);
        if (v >= (longint'(1) << 22)) v = v - (longint'(1) << 23);
        v = (v + 2048) >>> 12;
        if (v > 1023) v = 1023;
        if (v < -1024) v = -1024;
        return int'(v);
    endfunction

    function automatic int get_out(input int k);
        case (k / 8)
            0:       return int'(dout_R_add[k % 8]);
            1:       return int'(dout_Q_add[k % 8]);
            2:       return int'(dout_R_sub[k % 8]);
            default: return int'(dout_Q_sub[k % 8]);
        endcase
    endfunction

    always @(posedge clk) begin
        upd = en;
        if (en) ecnt++;
    end

    always @(negedge clk) begin
        if (rstn && upd && valid_out) begin
            if (sbq.size() == 0) begin
                check("unexpected_valid_out", 1, 0);
            end else begin
                exp_t e;
                int bad;
                int k;
                e = sbq.pop_front();
                bad = -1;
                for (int i = 0; i < 32; i++) begin
                    if (bad < 0 && get_out(i) != int'($signed(e.d[i]))) bad = i;
                end
                k = (bad < 0) ? 0 : bad;
                check($sformatf("dout[%0d]", k), get_out(k), int'($signed(e.d[k])));
                check("exp_add", exp_add, e.ea);
                check("exp_sub", exp_sub, e.eb);
                check("blk_idx", blk_idx, e.idx);
                check("blk_last", blk_last, (e.idx == 5'(BLKS - 1)));
                check("latency_en_edges", ecnt, e.edge_n);
            end
        end
    end

    task automatic issue(input logic vld, input logic [31:0][22:0] dv, input int ma, input int mb,
                         input bit use_c, input int ca, input int cb, input int ea, input int eb);
        exp_t e;
        en = 1'b1;
        valid_in = vld;
        for (int i = 0; i < 8; i++) begin
            din_R_add[i] = dv[i];
            din_Q_add[i] = dv[i + 8];
            din_R_sub[i] = dv[i + 16];
            din_Q_sub[i] = dv[i + 24];
        end
        mq_a.push_back(5'(ma));
        mq_b.push_back(5'(mb));
        min_in_add = mq_a.pop_front();
        min_in_sub = mq_b.pop_front();
        if (vld) begin
            for (int i = 0; i < 32; i++) begin
                if (use_c) e.d[i] = 11'((i < 16) ? ca : cb);
                else e.d[i] = 11'(ref_norm(int'($signed(dv[i])), (i < 16) ? ma : mb));
            end
            e.ea = 5'(use_c ? ea : ref_sh(ma));
            e.eb = 5'(use_c ? eb : ref_sh(mb));
            e.idx = 5'(model_idx);
            model_idx = (model_idx + 1) % BLKS;
            e.edge_n = 32'(ecnt + 1 + MIN_LAT);
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_data(output logic [31:0][22:0] dv);
        for (int i = 0; i < 32; i++) begin
            int val;
            val = int'($urandom) >>> $urandom_range(9, 31);
            dv[i] = val[22:0];
        end
    endtask

    task automatic rand_issue(input logic vld);
        logic [31:0][22:0] dv;
        rand_data(dv);
        issue(vld, dv, $urandom_range(0, 31), $urandom_range(0, 31), 1'b0, 0, 0, 0, 0);
    endtask

    task automatic stall(input int n);
        logic       vs;
        logic [4:0] bs;
        int         ds;
        lzc_t       xs;
        en = 1'b0;
        valid_in = 1'($urandom);
        min_in_add = 5'($urandom);
        min_in_sub = 5'($urandom);
        din_R_add[0] = 23'($urandom);
        vs = valid_out;
        bs = blk_idx;
        ds = get_out(0);
        xs = exp_add;
        repeat (n) @(posedge clk);
        #1;
        check("hold_valid_out", valid_out, vs);
        check("hold_blk_idx", blk_idx, bs);
        check("hold_dout", get_out(0), ds);
        check("hold_exp_add", exp_add, xs);
    endtask

    task automatic check_reset_outputs();
        int any;
        any = 0;
        for (int i = 0; i < 32; i++) if (get_out(i) != 0) any = 1;
        check("reset_valid_out", valid_out, 0);
        check("reset_dout_nonzero", any, 0);
        check("reset_exp_add", exp_add, 0);
        check("reset_exp_sub", exp_sub, 0);
        check("reset_blk_idx", blk_idx, 0);
        check("reset_blk_last", blk_last, 0);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #2;
        check_reset_outputs();
        sbq.delete();
        model_idx = 0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic drain();
        repeat (MIN_LAT + 2) rand_issue(1'b0);
    endtask

    // Directed vectors: din, min_add, min_sub, expected dout add/sub, expected exp add/sub.
    int t_din [6] = '{32'h000400, 32'h7FFC00, 32'h000C00, 32'h3FFFFF, 32'h000000, 32'h000400};
    int t_ma  [6] = '{11, 12, 0, 0, 31, 3};
    int t_mb  [6] = '{11, 12, 0, 0, 31, 9};
    int t_ca  [6] = '{512, -1024, 1, 1023, 0, 2};
    int t_cb  [6] = '{512, -1024, 1, 1023, 0, 128};
    int t_ea  [6] = '{11, 12, 0, 0, 22, 3};
    int t_eb  [6] = '{11, 12, 0, 0, 22, 9};

    initial begin
        logic [31:0][22:0] dv;
        for (int i = 0; i < 8; i++) begin
            din_R_add[i] = '0;
            din_Q_add[i] = '0;
            din_R_sub[i] = '0;
            din_Q_sub[i] = '0;
        end
        for (int i = 0; i < MIN_LAT; i++) begin
            mq_a.push_back(5'($urandom));
            mq_b.push_back(5'($urandom));
        end
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        rstn = 1'b1;
        @(posedge clk);
        #1;

        for (int t = 0; t < 6; t++) begin
            int v;
            v = t_din[t];
            for (int i = 0; i < 32; i++) dv[i] = v[22:0];
            issue(1'b1, dv, t_ma[t], t_mb[t], 1'b1, t_ca[t], t_cb[t], t_ea[t], t_eb[t]);
        end
        drain();

        for (int c = 0; c < 300; c++) begin
            if (c % 60 == 30) stall(4);
            rand_issue(1'($urandom_range(0, 3) != 0));
        end
        drain();

        do_reset();
        repeat (70) rand_issue(1'b1);
        drain();

        do_reset();
        repeat (40) rand_issue(1'b1);
        do_reset();
        repeat (10) rand_issue(1'b1);
        drain();

        check("scoreboard_empty", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
